// File: rtl/bcd_scan_display_pkg.sv
// Seven-segment patterns, the cathode decoder and the scan state type,
// shared across the display slice.
package disp_pkg;

    // Cathodes are {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // The display stays dark until the first scan strobe after reset.
    typedef enum logic {
        SCAN_IDLE,
        SCAN_RUN
    } scan_state_t;

    function automatic logic [6:0] bcd2seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Control and display signals of the BCD scan display; the board-side
// controller is the master, the display block is the slave.
interface bcd_scan_display_if #(
    parameter int N_DIG = 8
);
    localparam int NW = $clog2(N_DIG) + 1;

    logic                 en;
    logic                 up_dn;
    logic                 clr;
    logic                 load;
    logic [4*N_DIG-1:0]   load_val;
    logic [NW-1:0]        n_act;
    logic                 blank_lz;
    logic [N_DIG-1:0]     an;
    logic [6:0]           seg;
    logic [4*N_DIG-1:0]   bcd;
    logic                 carry;

    modport master (
        output en, up_dn, clr, load, load_val, n_act, blank_lz,
        input  an, seg, bcd, carry
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, n_act, blank_lz,
        output an, seg, bcd, carry
    );

endinterface

// File: rtl/bcd_scan_display_tick_gen.sv
// Free-running divider producing a one-cycle strobe every DIV clocks;
// the first strobe follows reset release by a full period.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the simulator runs blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// N-digit BCD up/down counter with runtime digit count, load/clear, wrap
// flag and a multiplexed, leading-zero-blanking seven-segment scan driver.
module bcd_scan_display
    import disp_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int N_DIG         = 8,
    parameter int SCAN_HZ       = 1000,
    parameter int COUNT_HZ      = 10,
    parameter int AN_ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              rst,
    bcd_scan_display_if.slave bus
);
    localparam int NW       = $clog2(N_DIG) + 1;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_DIV  = CLK_HZ / COUNT_HZ;
    localparam logic [N_DIG-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic scan_tk;
    logic cnt_tk;

    tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (.clk(clk), .rst(rst), .tick(scan_tk));
    tick_gen #(.DIV(CNT_DIV))  u_cnt_tick  (.clk(clk), .rst(rst), .tick(cnt_tk));

    logic [NW-1:0] n_eff;

    always_comb begin
        if (bus.n_act == '0)                n_eff = NW'(1);
        else if (bus.n_act > NW'(N_DIG))    n_eff = NW'(N_DIG);
        else                                n_eff = bus.n_act;
    end

    logic [N_DIG-1:0][3:0] bcd_q, bcd_d;
    logic                  carry_q, carry_d;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic ripple;
        bcd_d   = bcd_q;
        carry_d = 1'b0;
        ripple  = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (NW'(i) >= n_eff) bcd_d[i] = 4'd0;
        end
        if (bus.clr) begin
            bcd_d = '0;
        end else if (bus.load) begin
            for (int i = 0; i < N_DIG; i++) begin
                bcd_d[i] = (NW'(i) < n_eff && bus.load_val[4*i +: 4] <= 4'd9)
                         ? bus.load_val[4*i +: 4] : 4'd0;
            end
        end else if (cnt_tk && bus.en) begin
            // Carry/borrow ripples upward only while each active digit wraps.
            for (int i = 0; i < N_DIG; i++) begin
                if (NW'(i) < n_eff && ripple) begin
                    if (bus.up_dn) begin
                        if (bcd_d[i] == 4'd9) bcd_d[i] = 4'd0;
                        else begin
                            bcd_d[i] = bcd_d[i] + 4'd1;
                            ripple   = 1'b0;
                        end
                    end else begin
                        if (bcd_d[i] == 4'd0) bcd_d[i] = 4'd9;
                        else begin
                            bcd_d[i] = bcd_d[i] - 4'd1;
                            ripple   = 1'b0;
                        end
                    end
                end
            end
            carry_d = ripple;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
        end
    end

    scan_state_t   state_q, state_d;
    logic [NW-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (scan_tk) begin
            case (state_q)
                SCAN_IDLE: state_d = SCAN_RUN;
                SCAN_RUN:  idx_d = (idx_q == n_eff - NW'(1) || idx_q >= n_eff)
                                 ? '0 : idx_q + NW'(1);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    logic [3:0]       dig;
    logic             hi_zero;
    logic             lit;
    logic [N_DIG-1:0] on_vec;
    logic [N_DIG-1:0] an_d, an_q;
    logic [6:0]       seg_d, seg_q;

    always_comb begin
        dig     = 4'd0;
        hi_zero = 1'b1;
        on_vec  = '0;
        lit     = (state_q == SCAN_RUN || scan_tk) && (idx_q < n_eff);
        for (int i = 0; i < N_DIG; i++) begin
            if (NW'(i) == idx_q) begin
                dig       = bcd_q[i];
                on_vec[i] = lit;
            end
            if (NW'(i) >= idx_q && NW'(i) < n_eff && bcd_q[i] != 4'd0) hi_zero = 1'b0;
        end
        if (!lit)                                        seg_d = SEG_BLANK;
        else if (bus.blank_lz && idx_q != '0 && hi_zero) seg_d = SEG_BLANK;
        else                                             seg_d = bcd2seg(dig);
        an_d = (AN_ACTIVE_LOW != 0) ? ~on_vec : on_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.bcd   = bcd_q;
    assign bus.carry = carry_q;

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Parametrised N-digit BCD up/down counter with a multiplexed 7-segment scan driver.
- Runs entirely in the clk domain. Count and scan rates come from one-cycle strobes, not derived clocks.
- Sits between board-level control (switches/buttons) and the seven-segment anodes/cathodes.
- Adds a runtime active-digit count, count direction, load/clear, leading-zero blanking and a wrap (carry) flag.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- N_DIG, 8, number of physical digits; legal range 1..8.
- SCAN_HZ, 1000, digit-advance rate in Hz; divisor CLK_HZ/SCAN_HZ must be an integer ≥ 2.
- COUNT_HZ, 10, count-step rate in Hz; divisor CLK_HZ/COUNT_HZ must be an integer ≥ 2.
- AN_ACTIVE_LOW, 1, 1 means an anode is on when its bit is 0; 0 means on when 1.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, count enable; sampled on count strobe only.
- up_dn, in, 1, count direction: 1 = up, 0 = down.
- clr, in, 1, synchronous clear of the counter.
- load, in, 1, synchronous load of load_val.
- load_val, in, 4*N_DIG, BCD value to load; digit 0 in bits [3:0].
- n_act, in, $clog2(N_DIG)+1, number of active digits.
- blank_lz, in, 1, enable leading-zero blanking.
- an, out, N_DIG, anode drive, one-hot per polarity.
- seg, out, 7, cathodes {g,f,e,d,c,b,a}, active low.
- bcd, out, 4*N_DIG, current counter value.
- carry, out, 1, one-cycle pulse on wrap in either direction.

Behaviour:
- Reset (rst=1, async):
  - an = all digits off (all 1s if AN_ACTIVE_LOW, else all 0s).
  - seg = 7'h7F; bcd = 0; carry = 0; scan index idx = 0.
  - Both strobe dividers cleared.
- Reset mid-scan or mid-count forces these values immediately. First strobes come a full divisor period after deassertion.
- Strobes:
  - scan_tk pulses 1 cycle every CLK_HZ/SCAN_HZ cycles.
  - cnt_tk pulses 1 cycle every CLK_HZ/COUNT_HZ cycles.
  - Both are free-running and unaffected by en.
- Effective digit count: n_eff = 1 if n_act = 0; N_DIG if n_act > N_DIG; otherwise n_act. It is evaluated every cycle.
- Counter priority, each clk edge:
  - clr → bcd = 0.
  - Else load → bcd = load_val with digits ≥ n_eff forced to 0 and any nibble > 9 forced to 0.
  - Else cnt_tk & en → step by ±1 modulo 10^n_eff.
  - Else hold.
- Up step: ripple BCD carry through digits 0..n_eff-1. All-9s wraps to 0 and sets carry = 1 for one cycle.
- Down step: ripple borrow. All-zeros wraps to all-9s in digits 0..n_eff-1 and sets carry = 1 for one cycle.
- Digits ≥ n_eff always read 0. If n_act shrinks, those digits clear on the next clock.
- carry is registered and is 0 on any cycle without a wrap. clr and load never raise carry.
- Scan, on scan_tk:
  - idx = (idx == n_eff-1 || idx ≥ n_eff) ? 0 : idx+1.
  - Digits ≥ n_eff are never lit.
- Output latency: an and seg are registered and reflect idx and bcd one clk after they change.
- an: only bit idx is on.
- seg: 7-segment decode of digit idx.
- Leading-zero blanking: if blank_lz = 1, idx > 0, and digits idx..n_eff-1 are all 0, then seg = 7'h7F. Digit 0 is never blanked.
- Simultaneous cnt_tk and scan_tk: both act in the same cycle. The displayed digit uses post-step bcd one cycle later.

Decomposition:
- Shared package disp_pkg:
  - SEG_0..SEG_9 active-low patterns, e.g. SEG_5 = 7'h12, SEG_0 = 7'h40.
  - SEG_BLANK = 7'h7F.
  - Function bcd2seg (nibble > 9 decodes to SEG_BLANK).
- Sub-module tick_gen, parameter DIV: counter plus one-cycle strobe with async reset. Instantiated twice (scan, count).

Test Plan (sim params: CLK_HZ=1000, SCAN_HZ=100 → 10-cycle scan, COUNT_HZ=10 → 100-cycle count, N_DIG=4, AN_ACTIVE_LOW=1):
1. Assert rst mid-operation → same cycle: an = 4'hF, seg = 7'h7F, bcd = 0, carry = 0. Release → first an = 4'hE appears at the first scan tick plus 1 cycle.
2. n_act=4, load 16'h9999, en=1, up_dn=1 → at next cnt_tk: bcd = 16'h0000 and carry = 1 for exactly 1 cycle.
3. n_act=3, clr, up_dn=0, en=1 → at cnt_tk: bcd = 16'h0999 and carry pulse. Next cnt_tk → 16'h0998, carry = 0.
4. n_act=3, scan → an sequence 4'hE, 4'hD, 4'hB, 4'hE, changing every 10 cycles; 4'h7 never appears. Set n_act=0 → an stays 4'hE.
5. load 16'h0005, n_act=4, blank_lz=1 → idx0: seg = 7'h12; idx1..3: seg = 7'h7F. With blank_lz=0, idx1..3 show seg = 7'h40.
6. clr=1 and load=1 asserted on a cnt_tk cycle with en=1 → bcd = 0 and carry = 0. Then load 16'h12A4 → bcd = 16'h1204.
